rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_read_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Two-requester round-robin arbiter in front of a one-bit-wide combinational
//   ROM. A granted request reads LEN+1 consecutive ROM bits, starting at ADDR
//   and wrapping modulo 2**AW. The bits are packed LSB-first into RDATA, which
//   is returned to the owner with a VALID/READY handshake.
//
// Ports
//   CLK, RESETN          clock; asynchronous active-low reset
//   A_/B_VALID, _READY   request handshake (READY only in IDLE, only to grantee)
//   A_/B_ADDR, _LEN      burst start address and length minus one
//   A_/B_RVALID, _RREADY response handshake for the owning requester
//   RDATA                shared response word, qualified by x_RVALID
//   ROM_ADDR, ROM_DATA   registered ROM address / combinational ROM bit
module rom_read_arbiter #(
  parameter int AW = 7,
  parameter int LW = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [LW-1:0]    A_LEN,
  output logic             A_RVALID,
  input  logic             A_RREADY,
  input  logic             B_VALID,
  output logic             B_READY,
  input  logic [AW-1:0]    B_ADDR,
  input  logic [LW-1:0]    B_LEN,
  output logic             B_RVALID,
  input  logic             B_RREADY,
  output logic [2**LW-1:0] RDATA,
  output logic [AW-1:0]    ROM_ADDR,
  input  logic             ROM_DATA
);

  localparam int DW = 2**LW;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [LW-1:0]   idx_q, idx_d;      // RDATA bit written by the next sample
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            owner_q, owner_d;  // 0 = A, 1 = B
  logic            prio_q, prio_d;    // requester winning a tie: 0 = A, 1 = B

  logic grant_a, grant_b, accept, rsp_hs;

  // Grant is decided from the live VALIDs; READY is masked by reset so nothing
  // can be accepted while RESETN is low.
  assign grant_a = A_VALID && (!B_VALID || !prio_q);
  assign grant_b = B_VALID && (!A_VALID ||  prio_q);
  assign accept  = (state_q == IDLE) && (grant_a || grant_b);
  assign rsp_hs  = (state_q == RESP) && (owner_q ? B_RREADY : A_RREADY);

  assign A_READY  = RESETN && (state_q == IDLE) && grant_a;
  assign B_READY  = RESETN && (state_q == IDLE) && grant_b;
  assign A_RVALID = (state_q == RESP) && !owner_q;
  assign B_RVALID = (state_q == RESP) &&  owner_q;
  assign RDATA    = rdata_q;
  assign ROM_ADDR = rom_addr_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch); branches below only override.
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    owner_d    = owner_q;
    prio_d     = prio_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // ADDR/LEN are captured here; later input changes cannot affect
          // the burst.
          rom_addr_d = grant_a ? A_ADDR : B_ADDR;
          count_d    = grant_a ? A_LEN  : B_LEN;
          owner_d    = grant_b;
          idx_d      = '0;
          rdata_d    = '0;
          state_d    = READ;
        end
      end
      READ: begin
        rdata_d[idx_q] = ROM_DATA;
        rom_addr_d     = rom_addr_q + ADDR_ONE;  // wraps naturally mod 2**AW
        idx_d          = idx_q + LEN_ONE;
        if (count_q == '0) begin
          state_d = RESP;
        end else begin
          count_d = count_q - LEN_ONE;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          prio_d  = ~prio_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      rdata_q    <= '0;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
//   Directed bench for rom_read_arbiter. The ROM is modelled as bit[k] = k[0].
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rom_read_arbiter;

  localparam int AW = 7;
  localparam int LW = 4;
  localparam int DW = 2**LW;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          A_VALID, B_VALID, A_RREADY, B_RREADY;
  logic          A_READY, B_READY, A_RVALID, B_RVALID;
  logic [AW-1:0] A_ADDR, B_ADDR, ROM_ADDR;
  logic [LW-1:0] A_LEN, B_LEN;
  logic [DW-1:0] RDATA;
  logic          ROM_DATA;

  int passed = 0;
  int total  = 0;

  rom_read_arbiter #(.AW(AW), .LW(LW)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_LEN(A_LEN),
    .A_RVALID(A_RVALID), .A_RREADY(A_RREADY),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_LEN(B_LEN),
    .B_RVALID(B_RVALID), .B_RREADY(B_RREADY),
    .RDATA(RDATA), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
  );

  assign ROM_DATA = ROM_ADDR[0];

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Requester sel (0=A, 1=B) raises VALID in an IDLE cycle; the grant must
  // go to it alone. Its VALID drops after the accepting edge.
  task automatic accept(input string tag, input bit sel, input logic [AW-1:0] addr,
                        input logic [LW-1:0] len);
    if (sel) begin B_VALID = 1'b1; B_ADDR = addr; B_LEN = len; end
    else     begin A_VALID = 1'b1; A_ADDR = addr; A_LEN = len; end
    #1;
    check({tag, "_ready_own"},   sel ? B_READY : A_READY, 1);
    check({tag, "_ready_other"}, sel ? A_READY : B_READY, 0);
    tick();
    if (sel) B_VALID = 1'b0; else A_VALID = 1'b0;
  endtask

  // Called in cycle 1 of a burst: cycles 1..len+1 show no RVALID and no READY,
  // cycle len+2 shows owner RVALID with the expected word.
  task automatic wait_resp(input string tag, input bit sel, input int len,
                           input logic [DW-1:0] exp_data);
    logic early = 1'b0;
    for (int i = 1; i <= len + 1; i++) begin
      if (A_RVALID || B_RVALID || A_READY || B_READY) early = 1'b1;
      tick();
    end
    check({tag, "_quiet_in_read"}, early, 0);
    check({tag, "_rvalid_own"},    sel ? B_RVALID : A_RVALID, 1);
    check({tag, "_rvalid_other"},  sel ? A_RVALID : B_RVALID, 0);
    check({tag, "_rdata"},         RDATA, exp_data);
  endtask

  task automatic finish_resp(input string tag, input bit sel);
    if (sel) B_RREADY = 1'b1; else A_RREADY = 1'b1;
    tick();
    B_RREADY = 1'b0;
    A_RREADY = 1'b0;
    check({tag, "_rvalid_drop"}, {30'd0, A_RVALID, B_RVALID}, 0);
  endtask

  initial begin
    logic seen;
    RESETN = 1'b0;
    A_VALID = 0; B_VALID = 0; A_RREADY = 0; B_RREADY = 0;
    A_ADDR = '0; B_ADDR = '0; A_LEN = '0; B_LEN = '0;
    #2;
    check("rst_rdata",    RDATA, 0);
    check("rst_rom_addr", ROM_ADDR, 0);
    check("rst_rvalid",   {30'd0, A_RVALID, B_RVALID}, 0);
    A_VALID = 1'b1; B_VALID = 1'b1;
    #1;
    check("rst_ready_masked", {30'd0, A_READY, B_READY}, 0);
    A_VALID = 1'b0; B_VALID = 1'b0;
    tick();
    RESETN = 1'b1;

    // Basic burst; A changes ADDR/LEN right after accept, with no effect.
    accept("basic", 0, 7'd0, 4'd7);
    A_ADDR = 7'h55; A_LEN = 4'd0;
    wait_resp("basic", 0, 7, 16'h00AA);
    finish_resp("basic", 0);

    // Single-bit burst.
    accept("len0", 0, 7'd1, 4'd0);
    wait_resp("len0", 0, 0, 16'h0001);
    finish_resp("len0", 0);

    // Address wrap 126,127,0,1; ROM_ADDR holds 2 in RESP.
    accept("wrap", 0, 7'd126, 4'd3);
    wait_resp("wrap", 0, 3, 16'h000A);
    check("wrap_rom_addr_hold", ROM_ADDR, 2);
    finish_resp("wrap", 0);

    // Backpressure: addresses 3..8 -> 1,0,1,0,1,0 -> 0x15. B requests and
    // asserts its RREADY meanwhile; it must not be accepted or acknowledged.
    accept("bp", 0, 7'd3, 4'd5);
    wait_resp("bp", 0, 5, 16'h0015);
    B_VALID = 1'b1; B_ADDR = 7'd2; B_LEN = 4'd3; B_RREADY = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!A_RVALID || B_RVALID || B_READY || A_READY || RDATA !== 16'h0015 ||
          ROM_ADDR !== 7'd9) seen = 1'b1;
    end
    check("bp_stable", seen, 0);
    B_RREADY = 1'b0;
    finish_resp("bp", 0);
    // The pending B request was kept and is served now: 2..5 -> 0x000A.
    accept("bp_b", 1, 7'd2, 4'd3);
    wait_resp("bp_b", 1, 3, 16'h000A);
    finish_resp("bp_b", 1);

    // Contention from reset: A wins first, then B despite A re-requesting.
    tick();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    B_VALID = 1'b1; B_ADDR = 7'd5; B_LEN = 4'd2;   // 5,6,7 -> 1,0,1 -> 0x5
    accept("cont_a", 0, 7'd0, 4'd1);               // 0,1 -> 0x2
    A_VALID = 1'b1;                                // A re-requests at once
    wait_resp("cont_a", 0, 1, 16'h0002);
    finish_resp("cont_a", 0);
    accept("cont_b", 1, 7'd5, 4'd2);
    wait_resp("cont_b", 1, 2, 16'h0005);
    finish_resp("cont_b", 1);
    A_VALID = 1'b0;
    accept("cont_a2", 0, 7'd0, 4'd1);
    wait_resp("cont_a2", 0, 1, 16'h0002);
    finish_resp("cont_a2", 0);

    // Reset in cycle 4 of a 16-bit burst.
    accept("abort", 0, 7'd0, 4'd15);
    tick(); tick(); tick();                        // now in cycle 4
    RESETN = 1'b0;
    #1;
    check("abort_rdata",    RDATA, 0);
    check("abort_rom_addr", ROM_ADDR, 0);
    check("abort_rvalid",   {30'd0, A_RVALID, B_RVALID}, 0);
    tick();
    RESETN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (A_RVALID || B_RVALID) seen = 1'b1;
    end
    check("abort_no_resp", seen, 0);
    accept("fresh", 0, 7'd0, 4'd15);
    wait_resp("fresh", 0, 15, 16'hAAAA);
    finish_resp("fresh", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
